// File: rtl/fifo_drain_control.sv
// Drains one result tile from the column FIFOs (flat or deskewed) and emits unified-buffer row writes; optional abort under FIFO_DRAIN_ABORT_EN.
// Latency: first read 1 cycle after start, first write 1 cycle after column FIFO_WIDTH-1 is read, done 1 cycle after the tail write.
// Backpressure: none; start is accepted only in IDLE, and a drain runs at full rate until it completes, is aborted, or is reset.
module fifo_drain_control #(
    parameter int FIFO_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  deskew,
    input  logic [ADDR_WIDTH-1:0] base_addr,
`ifdef FIFO_DRAIN_ABORT_EN
    input  logic                  abort,
`endif
    output logic [FIFO_WIDTH-1:0] fifo_rd_en,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = $clog2(DEPTH + FIFO_WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_TAIL, S_DONE} state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         last_cnt;
    logic                  deskew_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] row;
    logic                  abort_i;

`ifdef FIFO_DRAIN_ABORT_EN
    assign abort_i = abort && (state == S_DRAIN || state == S_TAIL);
`else
    assign abort_i = 1'b0;
`endif

    assign last_cnt = deskew_q ? CW'(DEPTH + FIFO_WIDTH - 2) : CW'(DEPTH - 1);

    // In deskew mode column i lags column 0 by i cycles, following the array's diagonal output.
    always_comb begin
        fifo_rd_en = '0;
        if (state == S_DRAIN && !abort_i) begin
            for (int i = 0; i < FIFO_WIDTH; i++) begin
                if (deskew_q)
                    fifo_rd_en[i] = (cnt >= CW'(i)) && (cnt <= CW'(i + DEPTH - 1));
                else
                    fifo_rd_en[i] = (cnt <= CW'(DEPTH - 1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            deskew_q    <= 1'b0;
            base_q      <= '0;
            row         <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            // The last column completes each row, so its read data marks the row write.
            mem_wr_en <= fifo_rd_en[FIFO_WIDTH-1];
            if (fifo_rd_en[FIFO_WIDTH-1]) begin
                mem_wr_addr <= base_q + row;
                row         <= row + 1'b1;
            end
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_DRAIN;
                        deskew_q <= deskew;
                        base_q   <= base_addr;
                        cnt      <= '0;
                        row      <= '0;
                        busy     <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    cnt <= cnt + 1'b1;
                    if (abort_i) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else if (cnt == last_cnt) begin
                        state <= S_TAIL;
                    end
                end
                S_TAIL: begin
                    state <= S_DONE;
                    done  <= 1'b1;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_drain_control.sv
// Randomised drains against a cycle-indexed reference model; a negedge monitor pops expected writes/done pulses.
module tb_fifo_drain_control;

    localparam int W  = 16;
    localparam int D  = 16;
    localparam int AW = 8;

    typedef struct {
        int          c;
        logic [AW-1:0] a;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          deskew = 1'b0;
    logic [AW-1:0] base_addr = '0;
`ifdef FIFO_DRAIN_ABORT_EN
    logic          abort = 1'b0;
`endif
    logic [W-1:0]  fifo_rd_en;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic          busy;
    logic          done;

    int            cyc = 0;
    logic          rst_d = 1'b1;
    int            n_cmp = 0;
    int            n_fail = 0;
    logic [AW-1:0] last_addr = '0;

    wr_t           wq[$];
    int            dq[$];
    logic [W-1:0]  exp_rd[int];
    bit            exp_busy[int];

    always #5 clk = ~clk;

    fifo_drain_control #(.FIFO_WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .deskew     (deskew),
        .base_addr  (base_addr),
`ifdef FIFO_DRAIN_ABORT_EN
        .abort      (abort),
`endif
        .fifo_rd_en (fifo_rd_en),
        .mem_wr_en  (mem_wr_en),
        .mem_wr_addr(mem_wr_addr),
        .busy       (busy),
        .done       (done)
    );

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_d <= reset;
    end

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    // Expected behaviour of one drain started in cycle s; ab = absolute abort cycle or 0.
    task automatic model(int s, bit d, logic [AW-1:0] b, int ab);
        int t;
        int nw;
        int dn;
        t  = d ? D + W - 1 : D;
        nw = 0;
        dn = (ab > 0) ? ab + 1 : s + t + 2;
        for (int c = 1; c <= t; c++) begin
            int           cy;
            int           j;
            logic [W-1:0] v;
            wr_t          e;
            cy = s + c;
            j  = c - 1;
            if (ab > 0 && cy >= ab) break;
            for (int i = 0; i < W; i++)
                v[i] = d ? (j >= i && j <= i + D - 1) : (j < D);
            exp_rd[cy] = v;
            if (v[W-1]) begin
                e.c = cy + 1;
                e.a = AW'(int'(b) + nw);
                wq.push_back(e);
                nw++;
            end
        end
        for (int cy = s + 1; cy <= dn; cy++) exp_busy[cy] = 1'b1;
        dq.push_back(dn);
    endtask

    // A reset sampled at the end of cycle r wipes every expectation after r.
    task automatic cut(int r);
        wr_t keep_w[$];
        int  keep_d[$];
        foreach (wq[i]) if (wq[i].c <= r) keep_w.push_back(wq[i]);
        foreach (dq[i]) if (dq[i] <= r) keep_d.push_back(dq[i]);
        wq = keep_w;
        dq = keep_d;
        for (int c = r + 1; c <= r + 80; c++) begin
            exp_rd.delete(c);
            exp_busy.delete(c);
        end
    endtask

    always @(negedge clk) begin
        logic [W-1:0] er;
        bit           ew;
        bit           ed;
        wr_t          e;
        if (cyc >= 1) begin
            if (rst_d) last_addr = '0;
            er = exp_rd.exists(cyc) ? exp_rd[cyc] : '0;
            chk("rd_en", 64'(fifo_rd_en), 64'(er));
            chk("busy", 64'(busy), 64'(exp_busy.exists(cyc)));
            ew = (wq.size() > 0) && (wq[0].c == cyc);
            chk("wr_en", 64'(mem_wr_en), 64'(ew));
            if (ew) begin
                e = wq.pop_front();
                chk("wr_addr", 64'(mem_wr_addr), 64'(e.a));
                last_addr = e.a;
            end else begin
                chk("addr_hold", 64'(mem_wr_addr), 64'(last_addr));
            end
            ed = (dq.size() > 0) && (dq[0] == cyc);
            if (ed) void'(dq.pop_front());
            chk("done", 64'(done), 64'(ed));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(bit d, logic [AW-1:0] b, int ab_off, bit noise);
        int s;
        int t;
        int ab;
        int dn;
        s  = cyc;
        t  = d ? D + W - 1 : D;
        ab = (ab_off > 0) ? s + ab_off : 0;
        dn = (ab > 0) ? ab + 1 : s + t + 2;
        start = 1'b1;
        deskew = d;
        base_addr = b;
        model(s, d, b, ab);
        tick();
        start = 1'b0;
        while (cyc <= dn) begin
            if (noise) begin
                start     = ($urandom_range(0, 3) == 0) || (cyc == dn);
                deskew    = 1'($urandom);
                base_addr = AW'($urandom);
            end
`ifdef FIFO_DRAIN_ABORT_EN
            abort = (ab > 0) && (cyc == ab);
`endif
            tick();
        end
        start = 1'b0;
`ifdef FIFO_DRAIN_ABORT_EN
        abort = 1'b0;
`endif
    endtask

    task automatic reset_drain(bit d, logic [AW-1:0] b);
        int s;
        s = cyc;
        start = 1'b1;
        deskew = d;
        base_addr = b;
        model(s, d, b, 0);
        tick();
        start = 1'b0;
        while (cyc < s + 5) begin
            start = (cyc == s + 2);
            tick();
        end
        start = 1'b0;
        reset = 1'b1;
        cut(s + 5);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        tick();
        drain(1'b0, 8'h20, 0, 1'b0);
        drain(1'b1, 8'h00, 0, 1'b0);
        drain(1'b0, 8'hF8, 0, 1'b0);
        tick();
        drain(1'b0, 8'h40, 0, 1'b1);
        reset_drain(1'b0, 8'h55);
        tick();
        reset_drain(1'b1, 8'h10);
`ifdef FIFO_DRAIN_ABORT_EN
        drain(1'b0, 8'h30, 6, 1'b0);
        drain(1'b1, 8'h70, 20, 1'b0);
`endif
        for (int n = 0; n < 25; n++) begin
            int  ab_off;
            bit  d;
            d = 1'($urandom);
            ab_off = 0;
`ifdef FIFO_DRAIN_ABORT_EN
            if ($urandom_range(0, 3) == 0)
                ab_off = $urandom_range(1, d ? D + W : D + 1);
`endif
            drain(d, AW'($urandom), ab_off, 1'b1);
            repeat ($urandom_range(0, 3)) tick();
        end
        repeat (4) tick();
        chk("scoreboard_empty", 64'(wq.size() + dq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
